// File: rtl/btn_event_pkg.sv
// btn_event_pkg: state encoding plus default and simulation-scale timing for btn_event
package btn_event_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_GAP  = 3'd2,
    S_P2   = 3'd3,
    S_HOLD = 3'd4
  } state_t;
  localparam int unsigned CW_DEF     = 26;
  localparam int unsigned T_LONG_DEF = 50_000_000;
  localparam int unsigned T_DBL_DEF  = 15_000_000;
  localparam int unsigned T_REP_DEF  = 10_000_000;
  localparam int unsigned T_LONG_SIM = 20;
  localparam int unsigned T_DBL_SIM  = 8;
  localparam int unsigned T_REP_SIM  = 5;
endpackage

// File: rtl/btn_event_edge_det.sv
// edge_det: registers the previous key level and flags rising/falling edges
module edge_det #(
  parameter logic D_INIT = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic din_d;
  always_ff @(posedge clk)
    din_d <= !n_rst ? D_INIT : din;
  assign rise = din & ~din_d;
  assign fall = ~din & din_d;
endmodule

// File: rtl/btn_event.sv
// btn_event: turns a debounced key level into press/click/double-click/long-press pulses.
// Auto-repeat during a long hold is compiled in with BTN_EVENT_REPEAT_EN.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int unsigned CW     = CW_DEF,
  parameter int unsigned T_LONG = T_LONG_DEF,
  parameter int unsigned T_DBL  = T_DBL_DEF,
  parameter int unsigned T_REP  = T_REP_DEF,
  parameter logic        D_INIT = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic press,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic repeat_p,
  output logic held
);
  localparam longint unsigned LIM = (64'd1 << CW) - 64'd1;
  if (T_LONG < 2 || T_DBL < 2 || T_REP < 1 || 64'(T_LONG) > LIM || 64'(T_DBL) > LIM || 64'(T_REP) > LIM) begin : g_bad
    $error("btn_event: timing parameters out of range for CW");
  end
  localparam logic [CW-1:0] TL = CW'(T_LONG - 1);
  localparam logic [CW-1:0] TD = CW'(T_DBL - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt, ncnt;
  logic rise, fall, click_n, dclick_n, long_n, rep_n;
  edge_det #(.D_INIT(D_INIT)) u_edge (
    .clk(clk),
    .n_rst(n_rst),
    .din(din),
    .rise(rise),
    .fall(fall)
  );
  always_comb begin
    nxt = state;
    ncnt = cnt + CW'(1);
    click_n = 1'b0;
    dclick_n = 1'b0;
    long_n = 1'b0;
    rep_n = 1'b0;
    case (state)
      S_IDLE: begin
        ncnt = '0;
        nxt = rise ? S_P1 : S_IDLE;
      end
      S_P1:
        if (fall) begin
          nxt = S_GAP;
          ncnt = '0;
        end else if (cnt == TL) begin
          nxt = S_HOLD;
          ncnt = '0;
          long_n = 1'b1;
        end
      S_GAP:
        if (rise) begin
          nxt = S_P2;
          ncnt = '0;
        end else if (cnt == TD) begin
          nxt = S_IDLE;
          ncnt = '0;
          click_n = 1'b1;
        end
      S_P2:
        if (fall) begin
          nxt = S_IDLE;
          ncnt = '0;
          dclick_n = 1'b1;
        end else if (cnt == TL) begin
          nxt = S_HOLD;
          ncnt = '0;
          long_n = 1'b1;
        end
      S_HOLD: begin
`ifdef BTN_EVENT_REPEAT_EN
        if (fall) begin
          nxt = S_IDLE;
          ncnt = '0;
        end else if (cnt == CW'(T_REP - 1)) begin
          ncnt = '0;
          rep_n = 1'b1;
        end
`else
        ncnt = '0;
        nxt = fall ? S_IDLE : S_HOLD;
`endif
      end
      default: begin
        nxt = S_IDLE;
        ncnt = '0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (!n_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      press <= 1'b0;
      click <= 1'b0;
      dclick <= 1'b0;
      long_press <= 1'b0;
      repeat_p <= 1'b0;
      held <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= ncnt;
      press <= rise;
      click <= click_n;
      dclick <= dclick_n;
      long_press <= long_n;
      repeat_p <= rep_n;
      held <= nxt == S_P1 || nxt == S_P2 || nxt == S_HOLD;
    end
endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: directed scoreboard bench for btn_event at simulation-scale timing
module tb_btn_event;
  import btn_event_pkg::*;
  localparam logic [4:0] MP = 5'b00001, MC = 5'b00010, MD = 5'b00100, ML = 5'b01000, MR = 5'b10000;
  typedef struct {
    int cyc;
    logic [4:0] m;
  } ev_t;
  ev_t q[$];
  logic clk = 1'b0, n_rst = 1'b0, din = 1'b0;
  logic press, click, dclick, long_press, repeat_p, held;
  int cyc = 0, checks = 0, failures = 0, t;
  btn_event #(
    .CW(26), .T_LONG(T_LONG_SIM), .T_DBL(T_DBL_SIM), .T_REP(T_REP_SIM), .D_INIT(1'b0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .din(din), .press(press), .click(click), .dclick(dclick),
    .long_press(long_press), .repeat_p(repeat_p), .held(held)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic expect_ev(input int c, input logic [4:0] m);
    ev_t e;
    e.cyc = c;
    e.m = m;
    q.push_back(e);
  endtask
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask
  // Monitor: every observed pulse pattern pops the next expected event
  always @(negedge clk) begin
    logic [4:0] m;
    ev_t e;
    m = {repeat_p, long_press, dclick, click, press};
    if (n_rst && m != 5'b0) begin
      if (q.size() == 0) chk("unexpected_pulse", int'(m), 0);
      else begin
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_mask", int'(m), int'(e.m));
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({press, click, dclick, long_press, repeat_p, held}), 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    // short click
    t = cyc;
    expect_ev(t + 1, MP);
    expect_ev(t + 14, MC);
    hold(1, 5);
    hold(0, 20);
    // double click
    t = cyc;
    expect_ev(t + 1, MP);
    expect_ev(t + 9, MP);
    expect_ev(t + 14, MD);
    hold(1, 5); hold(0, 3); hold(1, 5); hold(0, 20);
    // long press, no click on release
    t = cyc;
    expect_ev(t + 1, MP);
    expect_ev(t + 21, ML);
`ifdef BTN_EVENT_REPEAT_EN
    expect_ev(t + 26, MR);
`endif
    hold(1, 10);
    chk("held_in_p1", int'(held), 1);
    hold(1, 15);
    chk("held_in_hold", int'(held), 1);
    hold(1, 5);
    hold(0, 3);
    chk("held_after_release", int'(held), 0);
    hold(0, 17);
    // rise coincident with gap terminal count
    t = cyc;
    expect_ev(t + 1, MP);
    expect_ev(t + 14, MP);
    expect_ev(t + 19, MD);
    hold(1, 5); hold(0, 8);
    hold(1, 3);
    chk("held_in_p2", int'(held), 1);
    hold(1, 2); hold(0, 20);
    // longer hold
    t = cyc;
    expect_ev(t + 1, MP);
    expect_ev(t + 21, ML);
`ifdef BTN_EVENT_REPEAT_EN
    expect_ev(t + 26, MR);
    expect_ev(t + 31, MR);
    expect_ev(t + 36, MR);
`endif
    hold(1, 40); hold(0, 20);
    // third press right after a double click
    t = cyc;
    expect_ev(t + 1, MP);
    expect_ev(t + 9, MP);
    expect_ev(t + 14, MD);
    expect_ev(t + 15, MP);
    expect_ev(t + 26, MC);
    hold(1, 5); hold(0, 3); hold(1, 5); hold(0, 1); hold(1, 3); hold(0, 20);
    // reset mid-P1 with key still held
    t = cyc;
    expect_ev(t + 1, MP);
    expect_ev(t + 8, MP);
    expect_ev(t + 28, ML);
    hold(1, 5);
    n_rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", int'({press, click, dclick, long_press, repeat_p, held}), 0);
    @(negedge clk);
    chk("mid_reset_outputs2", int'({press, click, dclick, long_press, repeat_p, held}), 0);
    n_rst = 1'b1;
    hold(1, 24);
    hold(0, 20);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
